// File: rtl/bsg_upstream_sched.sv
// rtl/bsg_upstream_sched.sv - two-requester 64-bit word scheduler onto a credited 2x8-bit link
// Optional feature: define BSG_UPSTREAM_SCHED_RR_EN for round-robin arbitration (default: requester 0 priority).
module bsg_upstream_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        core0_valid_in,
    input  logic [63:0] core0_data_in,
    output logic        core0_ready_out,
    input  logic        core1_valid_in,
    input  logic [63:0] core1_data_in,
    output logic        core1_ready_out,
    input  logic        io_token,
    output logic        io_valid_out,
    output logic [7:0]  io_data_out_ch0,
    output logic [7:0]  io_data_out_ch1,
    output logic [6:0]  outstanding,
    output logic        grant_id
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S0   = 3'd1;
    localparam logic [2:0] S1   = 3'd2;
    localparam logic [2:0] S2   = 3'd3;
    localparam logic [2:0] S3   = 3'd4;

    logic [2:0]  step;
    logic [31:0] data_cycle_0;
    logic [31:0] data_cycle_1;
    logic [6:0]  sent_cnt;
    logic [6:0]  finish_cnt;
    logic        last_grant;
    logic        accept_ok;
    logic        any_valid;
    logic        grant_sel;
    logic        accept;
    logic [63:0] grant_data;

    // Credits come only from registered counters, so a token never opens the window in its own cycle.
    assign outstanding = sent_cnt - finish_cnt;
    assign accept_ok   = ((step == IDLE) || (step == S3)) && (outstanding < 7'd64) && !rst;
    assign any_valid   = core0_valid_in | core1_valid_in;

    always_comb begin
        grant_sel = core1_valid_in;
        if (core0_valid_in && core1_valid_in) begin
`ifdef BSG_UPSTREAM_SCHED_RR_EN
            grant_sel = ~last_grant;
`else
            // Fixed priority; last_grant is still maintained so the RR build is a drop-in swap.
            grant_sel = 1'b0 & last_grant;
`endif
        end
    end

    assign accept          = accept_ok && any_valid;
    assign core0_ready_out = accept && !grant_sel;
    assign core1_ready_out = accept && grant_sel;
    assign grant_data      = grant_sel ? core1_data_in : core0_data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            step         <= IDLE;
            data_cycle_0 <= 32'd0;
            data_cycle_1 <= 32'd0;
            sent_cnt     <= 7'd0;
            finish_cnt   <= 7'd0;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
        end else begin
            if (accept) begin
                data_cycle_0 <= grant_data[31:0];
                data_cycle_1 <= grant_data[63:32];
                sent_cnt     <= sent_cnt + 7'd1;
                last_grant   <= grant_sel;
                grant_id     <= grant_sel;
                step         <= S0;
            end else begin
                case (step)
                    S0:      step <= S1;
                    S1:      step <= S2;
                    S2:      step <= S3;
                    default: step <= IDLE;
                endcase
            end
            if (io_token && (outstanding != 7'd0)) begin
                finish_cnt <= finish_cnt + 7'd1;
            end
        end
    end

    always_comb begin
        io_valid_out    = 1'b1;
        io_data_out_ch0 = 8'd0;
        io_data_out_ch1 = 8'd0;
        case (step)
            S0: begin
                io_data_out_ch0 = data_cycle_0[7:0];
                io_data_out_ch1 = data_cycle_0[23:16];
            end
            S1: begin
                io_data_out_ch0 = data_cycle_0[15:8];
                io_data_out_ch1 = data_cycle_0[31:24];
            end
            S2: begin
                io_data_out_ch0 = data_cycle_1[7:0];
                io_data_out_ch1 = data_cycle_1[23:16];
            end
            S3: begin
                io_data_out_ch0 = data_cycle_1[15:8];
                io_data_out_ch1 = data_cycle_1[31:24];
            end
            default: io_valid_out = 1'b0;
        endcase
    end

endmodule
